if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage for the EPU RV32I pipeline. It sits directly upstream of the decode stage and supplies it with `if_pc`/`if_ins` pairs. Memory is byte-wide behind the shared memory controller, so each 32-bit instruction is built from four byte reads, little-endian. The block holds the program counter, handles redirects from the execute stage, and holds its output while decode stalls.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: PC loaded on reset.

Ports:
- `clk_in`  in  1  — single clock; all state changes on its rising edge.
- `rst_in`  in  1  — reset, synchronous and active-high.
- `rdy_in`  in  1  — global enable; when low, all registers hold their values and no request is accepted.
- `stall_in`  in  1  — decode cannot accept the current output.
- `jump_flag`  in  1  — redirect request from execute.
- `jump_target`  in  32  — new PC, valid when `jump_flag` is high.
- `mem_req`  out  1  — byte read request.
- `mem_addr`  out  32  — byte address of the request.
- `mem_grant`  in  1  — the controller accepted `mem_addr` this cycle.
- `mem_dvalid`  in  1  — a returned byte is present on `mem_data`.
- `mem_data`  in  8  — returned byte.
- `if_valid`  out  1  — `if_pc` and `if_ins` hold a valid instruction.
- `if_pc`  out  32  — PC of the instruction.
- `if_ins`  out  32  — assembled instruction word.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `if_valid`=0, `if_pc`=0, `if_ins`=0, PC=`RESET_PC`, state=IDLE, all counters 0.
- **States:**
  - IDLE: always moves to FETCH on the next cycle.
  - FETCH: issues and collects the four bytes of one instruction.
  - HOLD: the word is assembled but the output register is occupied.
  - DRAIN: discards one in-flight byte after a redirect.
- **FETCH issue side:**
  - Drive `mem_req`=1 with `mem_addr` = PC + `issue_cnt` (`issue_cnt` runs 0..3).
  - A cycle with `mem_grant` advances `issue_cnt`. Without a grant, `mem_addr` is held unchanged.
  - `mem_req` drops once all four addresses are granted.
- **FETCH return side:**
  - Each `mem_dvalid` writes `mem_data` into byte lane `recv_cnt` of the assembly buffer, then increments `recv_cnt`.
  - Lane 0 maps to bits 7:0, lane 3 to bits 31:24.
- **Completion** (4th byte received):
  - If the output register is empty, or is being accepted this cycle (`if_valid` && !`stall_in`): load `if_ins` with the assembled word and `if_pc` with PC, set `if_valid`=1, set PC += 4, and return to FETCH.
  - Otherwise go to HOLD.
- **Output handshake:** the output is accepted on a cycle where `if_valid`=1 and `stall_in`=0. In that cycle `if_valid` clears, unless the same cycle loads a new word.
- **HOLD:** transfers the word to the output on the first cycle the output is accepted, then behaves as completion. `mem_req`=0 while in HOLD.
- **Redirect** (`jump_flag`=1) has priority over every other event:
  - Next cycle: `if_valid`=0, assembly buffer and counters cleared, PC=`jump_target`.
  - If `mem_grant` was high this cycle, one byte is still in flight: go to DRAIN, ignore the next `mem_dvalid` byte, then go to FETCH.
  - Otherwise go straight to FETCH.
- Redirect arriving in the same cycle as output acceptance: the output is dropped; decode flushes on its own side.
- Arithmetic: all PC and address math is 32-bit modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0. `jump_target` low bits are used as given; no alignment trap.
- `rdy_in`=0 freezes the whole system, including the memory controller, so no byte returns are lost.

## Timing
- Memory latency: a byte granted in cycle t returns with `mem_dvalid` in cycle t+1.
- With grants on every cycle:
  - Addresses are issued in cycles c..c+3.
  - Bytes arrive in cycles c+1..c+4.
  - `if_valid` goes high in cycle c+5.
  - The next instruction's first request is issued in cycle c+5, so sustained throughput is one instruction per 5 cycles.
- Redirect in cycle r: the first request at `jump_target` is issued in cycle r+1, or r+2 if DRAIN is needed.
- Reset asserted mid-fetch: next cycle all reset values apply. Later returning bytes are ignored because state is IDLE.

## Structure
- Shared defines header: `ZeroWord`, the state encodings (IDLE, FETCH, HOLD, DRAIN), and the instruction width.
- One sub-module, `fetch_assembler`: the byte-lane buffer plus `recv_cnt`, with clear, write, and complete signals. The FSM, PC and output register stay in `if_fetch`.

## Test plan
- Reset with `RESET_PC`=32'h0 and bytes 13,00,00,00 at addresses 0..3 → `mem_addr` 0,1,2,3 in cycles 1..4; `if_valid` with `if_ins`=32'h00000013, `if_pc`=0 in cycle 6.
- `mem_grant` low for 3 cycles on the byte at address 2 → `mem_addr` holds at 2; the assembled word is still correct, 3 cycles later.
- `stall_in` high for 10 cycles → the first output holds steady; the second word waits in HOLD with `mem_req`=0; both are delivered in order once `stall_in` drops.
- `jump_flag` with target 32'h100 in the same cycle as a grant of byte 1 → DRAIN discards one byte; next requests are 32'h100..32'h103; `if_pc`=32'h100.
- PC 32'hFFFFFFFC → the instruction is delivered, then the next fetch starts at 32'h0.
- `rst_in` pulsed during byte 2 of a fetch → `if_valid`=0 and `mem_req`=0 next cycle; the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word constants, instruction
// width and the fetch FSM state encoding.
package if_fetch_pkg;

  localparam int INS_WIDTH = 32;
  localparam logic [INS_WIDTH-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_assembler.sv
// Byte-lane assembly buffer: collects four little-endian bytes into one
// instruction word and flags the cycle in which the fourth byte lands.
module fetch_assembler
  import if_fetch_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 write,
  input  logic [7:0]           data,
  output logic                 complete,
  output logic [INS_WIDTH-1:0] word
);

  logic [INS_WIDTH-1:0] lane_buf_r;
  logic [1:0]           recv_cnt_r;

  assign complete = write && (recv_cnt_r == 2'd3);
  // Bypass the fourth byte so the word is usable in its arrival cycle.
  assign word     = complete ? {data, lane_buf_r[23:0]} : lane_buf_r;

  // Lane buffer and receive counter; counter wraps to 0 after the fourth byte.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lane_buf_r <= ZeroWord;
      recv_cnt_r <= 2'd0;
    end else if (rdy_in) begin
      if (clear) begin
        lane_buf_r <= ZeroWord;
        recv_cnt_r <= 2'd0;
      end else if (write) begin
        lane_buf_r[{recv_cnt_r, 3'b000} +: 8] <= data;
        recv_cnt_r                            <= recv_cnt_r + 2'd1;
      end else begin
        recv_cnt_r <= recv_cnt_r;
      end
    end else begin
      recv_cnt_r <= recv_cnt_r;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: issues four byte reads per instruction, owns the
// PC, handles execute-stage redirects and holds its output while decode stalls.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 stall_in,
  input  logic                 jump_flag,
  input  logic [31:0]          jump_target,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_grant,
  input  logic                 mem_dvalid,
  input  logic [7:0]           mem_data,
  output logic                 if_valid,
  output logic [31:0]          if_pc,
  output logic [INS_WIDTH-1:0] if_ins
);

  fetch_state_e         state_r, state_nxt_s;
  logic [31:0]          pc_r, pc_nxt_s;
  logic [1:0]           issue_cnt_r, issue_cnt_nxt_s;
  logic                 mem_req_nxt_s;
  logic [31:0]          mem_addr_nxt_s;
  logic                 if_valid_nxt_s;
  logic [31:0]          if_pc_nxt_s;
  logic [INS_WIDTH-1:0] if_ins_nxt_s;
  logic                 load_s;

  logic                 grant_s, accept_s, out_free_s;
  logic                 asm_write_s, asm_complete_s;
  logic [INS_WIDTH-1:0] asm_word_s;

  assign grant_s     = mem_req && mem_grant && (state_r == FETCH);
  assign accept_s    = if_valid && !stall_in;
  assign out_free_s  = !if_valid || accept_s;
  assign asm_write_s = (state_r == FETCH) && mem_dvalid && !jump_flag;

  fetch_assembler u_asm (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (jump_flag),
    .write    (asm_write_s),
    .data     (mem_data),
    .complete (asm_complete_s),
    .word     (asm_word_s)
  );

  // Next-state, request and output-register logic; redirect overrides everything.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    issue_cnt_nxt_s = issue_cnt_r;
    mem_req_nxt_s   = mem_req;
    mem_addr_nxt_s  = mem_addr;
    if_valid_nxt_s  = accept_s ? 1'b0 : if_valid;
    if_pc_nxt_s     = if_pc;
    if_ins_nxt_s    = if_ins;
    load_s          = 1'b0;

    if (jump_flag) begin
      if_valid_nxt_s  = 1'b0;
      pc_nxt_s        = jump_target;
      issue_cnt_nxt_s = 2'd0;
      if (grant_s) begin
        state_nxt_s   = DRAIN;
        mem_req_nxt_s = 1'b0;
      end else begin
        state_nxt_s    = FETCH;
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = jump_target;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s     = FETCH;
          mem_req_nxt_s   = 1'b1;
          mem_addr_nxt_s  = pc_r;
          issue_cnt_nxt_s = 2'd0;
        end
        FETCH: begin
          if (asm_complete_s) begin
            if (out_free_s) begin
              load_s = 1'b1;
            end else begin
              state_nxt_s   = HOLD;
              mem_req_nxt_s = 1'b0;
            end
          end else if (grant_s) begin
            if (issue_cnt_r == 2'd3) begin
              mem_req_nxt_s = 1'b0;
            end else begin
              issue_cnt_nxt_s = issue_cnt_r + 2'd1;
              mem_addr_nxt_s  = pc_r + {30'd0, issue_cnt_r + 2'd1};
            end
          end else begin
            state_nxt_s = FETCH;
          end
        end
        HOLD: begin
          mem_req_nxt_s = 1'b0;
          if (out_free_s) begin
            load_s = 1'b1;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        DRAIN: begin
          if (mem_dvalid) begin
            state_nxt_s     = FETCH;
            mem_req_nxt_s   = 1'b1;
            mem_addr_nxt_s  = pc_r;
            issue_cnt_nxt_s = 2'd0;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          mem_req_nxt_s = 1'b0;
        end
      endcase

      // Delivering a word also starts the next sequential fetch right away.
      if (load_s) begin
        if_valid_nxt_s  = 1'b1;
        if_pc_nxt_s     = pc_r;
        if_ins_nxt_s    = asm_word_s;
        pc_nxt_s        = pc_r + 32'd4;
        state_nxt_s     = FETCH;
        mem_req_nxt_s   = 1'b1;
        mem_addr_nxt_s  = pc_r + 32'd4;
        issue_cnt_nxt_s = 2'd0;
      end else begin
        if_pc_nxt_s = if_pc;
      end
    end
  end

  // State, PC and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      issue_cnt_r <= 2'd0;
      mem_req     <= 1'b0;
      mem_addr    <= ZeroWord;
      if_valid    <= 1'b0;
      if_pc       <= ZeroWord;
      if_ins      <= ZeroWord;
    end else if (rdy_in) begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      issue_cnt_r <= issue_cnt_nxt_s;
      mem_req     <= mem_req_nxt_s;
      mem_addr    <= mem_addr_nxt_s;
      if_valid    <= if_valid_nxt_s;
      if_pc       <= if_pc_nxt_s;
      if_ins      <= if_ins_nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

endmodule
